cpu7_ifu_fdpq: RTL and testbench
================================

CPU7_IFU_FDPQ -- requirements
Module: cpu7_ifu_fdpq

Interface
REQ-001 Parameter: DEPTH, default 4, fetch-queue entries; power of 2, 2..16.
REQ-002 Parameter: MAX_OUTST, default 2, maximum outstanding fetch requests; 1..4.
REQ-003 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: pc_init  in  32  fetch start address, sampled during reset.
REQ-006 Port: inst_req / inst_addr  out  1 / 32  fetch request and its word address.
REQ-007 Port: inst_addr_ok  in  1  request accepted this cycle, valid only when inst_req=1.
REQ-008 Port: inst_valid / inst_rdata / inst_ex / inst_exccode  in  1 / 128 / 1 / 6  in-order response; instruction is inst_rdata[31:0].
REQ-009 Port: inst_cancel  out  1  one-cycle pulse on redirect.
REQ-010 Port: br_taken / br_target  in  1 / 32  branch redirect from execute.
REQ-011 Port: exu_ifu_except / exu_ifu_eentry  in  1 / GRLEN  exception redirect.
REQ-012 Port: exu_ifu_stall_req  in  1  decode cannot accept.
REQ-013 Port: fdp_dec_valid / fdp_dec_inst / fdp_dec_pc / fdp_dec_ex / fdp_dec_exccode  out  1 / 32 / 32 / 1 / 6  queue head to decode.

Function
REQ-014 The block SHALL hold fetch PC register pc_bf: reset value pc_init; +4 on each accepted request (inst_req & inst_addr_ok); redirect value on redirect.
REQ-015 Redirect SHALL equal exu_ifu_except | br_taken; target SHALL be exu_ifu_eentry when exu_ifu_except=1, otherwise br_target (exception wins when simultaneous).
REQ-016 inst_cancel SHALL equal redirect combinationally; inst_req SHALL be 0 in the redirect cycle.
REQ-017 inst_req SHALL be 1 only when ~reset, ~redirect, ~fault_hold, outst < MAX_OUTST, and outst + occupancy < DEPTH (credit rule, no overflow possible).
REQ-018 The outst counter SHALL increment on accept, decrement on inst_valid, and stay unchanged when both occur.
REQ-019 Each request SHALL push its PC into a pending-PC FIFO (depth MAX_OUTST); each response pops it and enqueues {pc, inst, ex, exccode}.
REQ-020 On redirect: fetch queue and pending-PC FIFO SHALL be flushed; drop_cnt SHALL load outst (minus 1 if inst_valid this cycle); subsequent responses SHALL be discarded while drop_cnt>0, decrementing drop_cnt; outst SHALL track normally.
REQ-021 A response with inst_ex=1 SHALL set fault_hold, suppressing requests until the next redirect clears it.
REQ-022 fdp_dec_valid SHALL be (occupancy>0) & ~exu_ifu_stall_req & ~redirect; the head SHALL be dequeued when fdp_dec_valid=1.
REQ-023 Response-to-fdp_dec_valid latency SHALL be exactly 1 cycle into an empty queue; no bypass.
REQ-024 Simultaneous enqueue and dequeue SHALL be legal at any occupancy, including full; occupancy unchanged.
REQ-025 Queue pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits.

Reset
REQ-026 During reset: inst_req=0, inst_cancel=0, fdp_dec_valid=0, fdp_dec_inst/pc=0, fdp_dec_ex=0, fdp_dec_exccode=0, occupancy=outst=drop_cnt=0, fault_hold=0, pc_bf=pc_init.
REQ-027 Reset asserted mid-operation SHALL discard all state in one cycle; responses arriving after deassertion for pre-reset requests are outside contract.

Structure
REQ-028 GRLEN and the exccode width SHALL come from common.vh; no new package constants beyond those.
REQ-029 The fetch queue SHALL be one sub-module, cpu7_ifu_fq (parametrised width/depth, push/pop/flush, occupancy output), instantiated twice (instruction queue, pending-PC FIFO).

Verification
REQ-030 Reset with pc_init=0x1C000000, memory always ready, 1-cycle latency -> decode sees PCs 0x1C000000, +4, +8 on consecutive cycles after the first fill.
REQ-031 DEPTH=4, stall held 10 cycles -> exactly 4 entries are queued, inst_req=0, no overflow; release drains 4 entries in order.
REQ-032 br_taken with target 0x1C000100 and 2 outstanding -> inst_cancel pulses once, both late responses are discarded, first decode PC is 0x1C000100.
REQ-033 br_taken and exu_ifu_except in the same cycle, eentry=0x1C008000 -> fetch resumes at 0x1C008000.
REQ-034 Response with inst_ex=1, exccode=0x08 -> entry is delivered with fdp_dec_ex=1 and exccode 0x08, no further requests until a redirect.
REQ-035 Reset asserted with a full queue -> the next cycle shows fdp_dec_valid=0, inst_req=0, occupancy 0.

Source files
------------

// File: rtl/cpu7_ifu_fdpq_pkg.sv
// Shared widths and the fetch-queue entry layout for the fetch/decode pipe.
package cpu7_ifu_fdpq_pkg;

  // Architectural register width and exception-code width of the core.
  localparam int unsigned GRLEN     = 32;
  localparam int unsigned EXCCODE_W = 6;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic                 ex;
    logic [EXCCODE_W-1:0] exccode;
  } fdp_entry_t;

endpackage

// File: rtl/cpu7_ifu_fq.sv
// Generic synchronous FIFO with flush; pointers wrap modulo DEPTH.
module cpu7_ifu_fq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CntW-1:0]  occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  // Storage write; data needs no reset since occupancy gates its use.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data  = mem[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: rtl/cpu7_ifu_fdpq.sv
// Fetch PC generation, request credit control and fetch queue feeding decode.
module cpu7_ifu_fdpq
  import cpu7_ifu_fdpq_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          pc_init,
  output logic                 inst_req,
  output logic [31:0]          inst_addr,
  input  logic                 inst_addr_ok,
  input  logic                 inst_valid,
  input  logic [127:0]         inst_rdata,
  input  logic                 inst_ex,
  input  logic [EXCCODE_W-1:0] inst_exccode,
  output logic                 inst_cancel,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 exu_ifu_except,
  input  logic [GRLEN-1:0]     exu_ifu_eentry,
  input  logic                 exu_ifu_stall_req,
  output logic                 fdp_dec_valid,
  output logic [31:0]          fdp_dec_inst,
  output logic [31:0]          fdp_dec_pc,
  output logic                 fdp_dec_ex,
  output logic [EXCCODE_W-1:0] fdp_dec_exccode
);

  localparam int unsigned OutW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned PendW = $clog2(MAX_OUTST) + 1;

  logic [31:0]      pc_bf_q;
  logic [OutW-1:0]  outst_q, drop_cnt_q;
  logic             fault_hold_q;
  logic             redirect, accept, rsp_live, credit_ok;
  logic [31:0]      redirect_pc, rsp_pc;
  logic [CntW-1:0]  occupancy;
  logic [PendW-1:0] pend_occupancy;
  fdp_entry_t       rsp_entry, head;
  logic             unused_bits;

  assign redirect    = exu_ifu_except | br_taken;
  assign redirect_pc = exu_ifu_except ? exu_ifu_eentry[31:0] : br_target;
  // Counting outstanding requests against free queue slots guarantees every response has room.
  assign credit_ok   = (32'(outst_q) < MAX_OUTST) && (32'(outst_q) + 32'(occupancy) < DEPTH);
  assign accept      = inst_req & inst_addr_ok;
  // Responses owed to requests issued before a redirect are dropped by count.
  assign rsp_live    = inst_valid & ~redirect & ~reset & (drop_cnt_q == '0);
  assign rsp_entry   = '{pc: rsp_pc, inst: inst_rdata[31:0], ex: inst_ex, exccode: inst_exccode};
  assign unused_bits = ^{inst_rdata[127:32], pend_occupancy};

  // Request, cancel and decode-side outputs, all forced quiet during reset.
  always_comb begin
    inst_req        = ~reset & ~redirect & ~fault_hold_q & credit_ok;
    inst_addr       = pc_bf_q;
    inst_cancel     = redirect & ~reset;
    fdp_dec_valid   = ~reset & ~redirect & ~exu_ifu_stall_req & (occupancy != '0);
    fdp_dec_inst    = '0;
    fdp_dec_pc      = '0;
    fdp_dec_ex      = 1'b0;
    fdp_dec_exccode = '0;
    if (!reset) begin
      fdp_dec_inst    = head.inst;
      fdp_dec_pc      = head.pc;
      fdp_dec_ex      = head.ex;
      fdp_dec_exccode = head.exccode;
    end
  end

  // Fetch PC, outstanding/drop counters and fault hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_bf_q      <= pc_init;
      outst_q      <= '0;
      drop_cnt_q   <= '0;
      fault_hold_q <= 1'b0;
    end else begin
      if (redirect)    pc_bf_q <= redirect_pc;
      else if (accept) pc_bf_q <= pc_bf_q + 32'd4;

      if (accept && !inst_valid)      outst_q <= outst_q + OutW'(1);
      else if (!accept && inst_valid) outst_q <= outst_q - OutW'(1);

      if (redirect)                            drop_cnt_q <= outst_q - OutW'(inst_valid);
      else if (inst_valid && drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - OutW'(1);

      if (redirect)                fault_hold_q <= 1'b0;
      else if (rsp_live && inst_ex) fault_hold_q <= 1'b1;
    end
  end

  // PCs of requests in flight, matched in order with responses.
  cpu7_ifu_fq #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_pend_fq (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (accept),
    .push_data (pc_bf_q),
    .pop       (rsp_live),
    .pop_data  (rsp_pc),
    .occupancy (pend_occupancy)
  );

  // Instruction queue presented to decode.
  cpu7_ifu_fq #(
    .WIDTH ($bits(fdp_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fq (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (rsp_live),
    .push_data (rsp_entry),
    .pop       (fdp_dec_valid),
    .pop_data  (head),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_cpu7_ifu_fdpq.sv
// Randomized bench for cpu7_ifu_fdpq against an epoch-tagged memory/queue model.
module tb_cpu7_ifu_fdpq;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;

  logic         clock, reset;
  logic [31:0]  pc_init;
  logic         inst_req, inst_addr_ok, inst_valid, inst_ex, inst_cancel;
  logic [31:0]  inst_addr, br_target, exu_ifu_eentry;
  logic [127:0] inst_rdata;
  logic [5:0]   inst_exccode, fdp_dec_exccode;
  logic         br_taken, exu_ifu_except, exu_ifu_stall_req;
  logic         fdp_dec_valid, fdp_dec_ex;
  logic [31:0]  fdp_dec_inst, fdp_dec_pc;

  cpu7_ifu_fdpq #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clock             (clock),
    .reset             (reset),
    .pc_init           (pc_init),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_addr_ok      (inst_addr_ok),
    .inst_valid        (inst_valid),
    .inst_rdata        (inst_rdata),
    .inst_ex           (inst_ex),
    .inst_exccode      (inst_exccode),
    .inst_cancel       (inst_cancel),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .exu_ifu_except    (exu_ifu_except),
    .exu_ifu_eentry    (exu_ifu_eentry),
    .exu_ifu_stall_req (exu_ifu_stall_req),
    .fdp_dec_valid     (fdp_dec_valid),
    .fdp_dec_inst      (fdp_dec_inst),
    .fdp_dec_pc        (fdp_dec_pc),
    .fdp_dec_ex        (fdp_dec_ex),
    .fdp_dec_exccode   (fdp_dec_exccode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: requests in flight tagged with the redirect epoch they were issued in.
  typedef struct {logic [31:0] pc; int ep;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic ex; logic [5:0] code;} ent_t;
  req_t        memq[$];
  ent_t        q[$];
  int          epoch;
  bit          m_fault;
  logic [31:0] m_fetch_pc;

  int p_stall, p_br, p_exc, p_ok, p_resp, p_fault;
  bit force_br, force_exc;
  logic [31:0] force_tgt, force_eentry;

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, pc[31:16]};
  endfunction

  function automatic logic [31:0] rand_aligned();
    logic [31:0] t;
    t = $urandom();
    return {t[31:2], 2'b00};
  endfunction

  task automatic step();
    bit   redir, exp_req, exp_dv, live;
    req_t r;
    ent_t e;
    @(negedge clock);
    exu_ifu_stall_req = roll(p_stall);
    br_taken          = force_br | roll(p_br);
    br_target         = force_br ? force_tgt : rand_aligned();
    exu_ifu_except    = force_exc | roll(p_exc);
    exu_ifu_eentry    = force_exc ? force_eentry : rand_aligned();
    force_br          = 1'b0;
    force_exc         = 1'b0;
    inst_addr_ok      = roll(p_ok);
    inst_valid        = (memq.size() > 0) && roll(p_resp);
    inst_rdata        = {$urandom(), $urandom(), $urandom(), $urandom()};
    inst_ex           = 1'b0;
    inst_exccode      = 6'h0;
    if (inst_valid) begin
      inst_rdata[31:0] = inst_of(memq[0].pc);
      inst_ex          = roll(p_fault);
      inst_exccode     = inst_ex ? 6'($urandom_range(63)) : 6'h0;
    end
    #1;
    redir   = br_taken | exu_ifu_except;
    exp_req = !redir && !m_fault && memq.size() < MAX_OUTST &&
              (memq.size() + q.size()) < DEPTH;
    exp_dv  = q.size() > 0 && !exu_ifu_stall_req && !redir;
    check("inst_cancel", inst_cancel, redir);
    check("inst_req", inst_req, exp_req);
    if (exp_req) check("inst_addr", inst_addr, m_fetch_pc);
    check("dec_valid", fdp_dec_valid, exp_dv);
    if (exp_dv) begin
      check("dec_pc", fdp_dec_pc, q[0].pc);
      check("dec_inst", fdp_dec_inst, q[0].inst);
      check("dec_ex", fdp_dec_ex, q[0].ex);
      check("dec_exccode", fdp_dec_exccode, q[0].code);
    end
    live = 1'b0;
    if (inst_valid) begin
      r    = memq.pop_front();
      live = !redir && r.ep == epoch;
    end
    if (redir) begin
      q.delete();
      m_fault    = 1'b0;
      epoch++;
      m_fetch_pc = exu_ifu_except ? exu_ifu_eentry : br_target;
    end else begin
      if (exp_dv) void'(q.pop_front());
      if (live) begin
        e.pc   = r.pc;
        e.inst = inst_rdata[31:0];
        e.ex   = inst_ex;
        e.code = inst_exccode;
        q.push_back(e);
        if (inst_ex) m_fault = 1'b1;
      end
      if (exp_req && inst_addr_ok) begin
        r.pc = m_fetch_pc;
        r.ep = epoch;
        memq.push_back(r);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  // Two reset cycles with outputs checked quiet; a redirect is driven in the first.
  task automatic apply_reset(input logic [31:0] pc);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      reset             = 1'b1;
      pc_init           = pc;
      br_taken          = (i == 0);
      br_target         = 32'h0000_1000;
      exu_ifu_except    = 1'b0;
      exu_ifu_stall_req = 1'b0;
      inst_addr_ok      = 1'b1;
      inst_valid        = 1'b0;
      inst_ex           = 1'b0;
      #1;
      check("rst_inst_req", inst_req, 1'b0);
      check("rst_cancel", inst_cancel, 1'b0);
      check("rst_dec_valid", fdp_dec_valid, 1'b0);
      check("rst_dec_pc", fdp_dec_pc, 32'h0);
      check("rst_dec_inst", fdp_dec_inst, 32'h0);
      check("rst_dec_ex", {fdp_dec_ex, fdp_dec_exccode}, 7'h0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    memq.delete();
    q.delete();
    m_fault    = 1'b0;
    epoch++;
    m_fetch_pc = pc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_knobs(input int st, input int br, input int ex, input int ok,
                           input int rs, input int ft);
    p_stall = st; p_br = br; p_exc = ex; p_ok = ok; p_resp = rs; p_fault = ft;
  endtask

  initial begin
    reset = 1'b1; pc_init = '0; inst_addr_ok = 0; inst_valid = 0; inst_rdata = '0;
    inst_ex = 0; inst_exccode = '0; br_taken = 0; br_target = '0; exu_ifu_except = 0;
    exu_ifu_eentry = '0; exu_ifu_stall_req = 0; force_br = 0; force_exc = 0;
    force_tgt = '0; force_eentry = '0; epoch = 0; m_fault = 0; m_fetch_pc = '0;

    // Always-ready memory, sequential fetch from reset PC.
    apply_reset(32'h1C00_0000);
    set_knobs(0, 0, 0, 100, 100, 0);
    run(20);
    // Decode stalled long enough to fill the queue, then released.
    set_knobs(100, 0, 0, 100, 100, 0);
    run(12);
    set_knobs(0, 0, 0, 100, 100, 0);
    run(10);
    // Branch with two requests in flight.
    set_knobs(100, 0, 0, 100, 0, 0);
    run(3);
    force_br = 1; force_tgt = 32'h1C00_0100;
    run(1);
    set_knobs(0, 0, 0, 100, 100, 0);
    run(12);
    // Branch and exception together: exception target wins.
    force_br = 1; force_tgt = 32'h1C00_2000;
    force_exc = 1; force_eentry = 32'h1C00_8000;
    run(12);
    // Faulting fetch stops requests until a redirect.
    set_knobs(0, 0, 0, 100, 100, 100);
    run(2);
    set_knobs(0, 0, 0, 100, 100, 0);
    run(10);
    force_br = 1; force_tgt = 32'h1C00_0400;
    run(10);
    // Random traffic.
    set_knobs(30, 4, 1, 70, 60, 3);
    run(3000);
    // Reset with a full queue.
    set_knobs(100, 0, 0, 100, 100, 0);
    run(12);
    apply_reset(rand_aligned());
    set_knobs(25, 3, 1, 80, 70, 2);
    run(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
